// File: rtl/priority_arbiter_3req.sv
// -----------------------------------------------------------------------------
// priority_arbiter_3req
//
// Shares one downstream resource among three requesters. A winner is picked
// from the eligible requests (bit 0 highest priority by default), and its
// one-hot grant, encoded index and valid flag are registered. The grant is held
// while the owner keeps requesting, with no preemption. After MAX_HOLD
// consecutive cycles the grant is revoked, timeout pulses for one cycle, and
// the owner is penalised until it drops its request.
//
// Build option:
//   PRIORITY_ARB_ROUND_ROBIN_EN - when defined, the priority search starts one
//   position after the last owner (wrapping 2 -> 0 -> 1 -> 2). When undefined,
//   the order is fixed at bit 0 > bit 1 > bit 2 and no pointer is built.
//
// Parameters:
//   MAX_HOLD  maximum consecutive grant cycles per owner (2..65535)
//   CNT_W     hold counter width (derived, do not override)
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset
//   req[2:0] in   request per requester, held high while ownership is wanted
//   gnt[2:0] out  registered one-hot grant, 000 when no owner
//   out[1:0] out  registered owner index, 00 when no owner
//   valid    out  registered, high when gnt is non-zero
//   timeout  out  registered one-cycle pulse on MAX_HOLD revocation
// -----------------------------------------------------------------------------
module priority_arbiter_3req #(
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = $clog2(MAX_HOLD + 1)
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] req,
   output logic [2:0] gnt,
   output logic [1:0] out,
   output logic       valid,
   output logic       timeout
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

   state_t           state;
   logic [CNT_W-1:0] hold_cnt;
   logic [2:0]       penalty;

   logic [2:0]       elig;
   logic [1:0]       start;
   logic [1:0]       win_idx;
   logic             owner_req;

`ifdef PRIORITY_ARB_ROUND_ROBIN_EN
   logic [1:0]       last_owner;
`endif

   // Highest-priority set bit of e, searching s, s+1, s+2 (mod 3).
   // The result is don't-care when e is zero; callers qualify it with |e.
   function automatic logic [1:0] pick(input logic [2:0] e, input logic [1:0] s);
      logic [1:0] a, b, c;
      case (s)
         2'd1:    begin a = 2'd1; b = 2'd2; c = 2'd0; end
         2'd2:    begin a = 2'd2; b = 2'd0; c = 2'd1; end
         default: begin a = 2'd0; b = 2'd1; c = 2'd2; end
      endcase
      if (e[a])      pick = a;
      else if (e[b]) pick = b;
      else           pick = c;
   endfunction

   // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
   always_comb begin
      elig      = req & ~penalty;
      // The owner is still requesting when its own grant bit meets its req bit.
      owner_req = |(req & gnt);
`ifdef PRIORITY_ARB_ROUND_ROBIN_EN
      start     = (last_owner == 2'd2) ? 2'd0 : last_owner + 2'd1;
`else
      start     = 2'd0;
`endif
      win_idx   = pick(elig, start);
   end

   // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         gnt      <= 3'b000;
         out      <= 2'b00;
         valid    <= 1'b0;
         timeout  <= 1'b0;
         hold_cnt <= '0;
         penalty  <= 3'b000;
`ifdef PRIORITY_ARB_ROUND_ROBIN_EN
         last_owner <= 2'd2;
`endif
      end else begin
         timeout <= 1'b0;
         // A penalty lasts only while that requester keeps its bit high.
         penalty <= penalty & req;

         case (state)
            IDLE: begin
               if (|elig) begin
                  gnt      <= 3'b001 << win_idx;
                  out      <= win_idx;
                  valid    <= 1'b1;
                  hold_cnt <= '0;
                  state    <= BUSY;
`ifdef PRIORITY_ARB_ROUND_ROBIN_EN
                  last_owner <= win_idx;
`endif
               end
            end

            BUSY: begin
               if (!owner_req) begin
                  // Voluntary release wins over a coincident expiry.
                  gnt   <= 3'b000;
                  out   <= 2'b00;
                  valid <= 1'b0;
                  state <= IDLE;
               end else if (hold_cnt == HOLD_LAST) begin
                  gnt     <= 3'b000;
                  out     <= 2'b00;
                  valid   <= 1'b0;
                  timeout <= 1'b1;
                  // The owner's req is high here, so OR-ing gnt in sets its penalty.
                  penalty <= (penalty & req) | gnt;
                  state   <= IDLE;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_priority_arbiter_3req.sv
// -----------------------------------------------------------------------------
// tb_priority_arbiter_3req
//
// Directed bench for priority_arbiter_3req with MAX_HOLD = 4. The observed
// outputs are packed as {timeout, valid, out, gnt}. Each one is compared with
// a hand-computed value one time unit after the rising edge. The fairness
// sequence expects the round-robin order when PRIORITY_ARB_ROUND_ROBIN_EN is
// defined and the fixed order when it is not.
// -----------------------------------------------------------------------------
module tb_priority_arbiter_3req;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] req;
   logic [2:0] gnt;
   logic [1:0] out;
   logic       valid;
   logic       timeout;

   int n_vec = 0;
   int n_bad = 0;

   priority_arbiter_3req #(.MAX_HOLD(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .gnt     (gnt),
      .out     (out),
      .valid   (valid),
      .timeout (timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got t/v/out/gnt=%b expected %b", tag, got, exp);
      end
   endtask

   // Compare all outputs against the expected grant, index, valid and timeout.
   task automatic expect_out(input string tag, input logic [2:0] g, input logic [1:0] o,
                             input logic v, input logic t);
      check(tag, {timeout, valid, out, gnt}, {t, v, o, g});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [1:0] rr_exp [4];

   initial begin
`ifdef PRIORITY_ARB_ROUND_ROBIN_EN
      rr_exp = '{2'd0, 2'd1, 2'd2, 2'd0};
`else
      rr_exp = '{2'd0, 2'd0, 2'd0, 2'd0};
`endif
      rst = 1'b1;
      req = 3'b000;
      tick();
      tick();
      expect_out("reset", 3'b000, 2'd0, 1'b0, 1'b0);
      rst = 1'b0;

      // Single request and release.
      req = 3'b100; tick();
      expect_out("single_grant", 3'b100, 2'd2, 1'b1, 1'b0);
      req = 3'b000; tick();
      expect_out("single_release", 3'b000, 2'd0, 1'b0, 1'b0);

      // Simultaneous requests, then hand-over with a dead slot.
      req = 3'b111; tick();
      expect_out("simul_111", 3'b001, 2'd0, 1'b1, 1'b0);
      req = 3'b110; tick();
      expect_out("handover_dead", 3'b000, 2'd0, 1'b0, 1'b0);
      tick();
      expect_out("handover_110", 3'b010, 2'd1, 1'b1, 1'b0);
      req = 3'b100; tick();
      expect_out("drop_owner1", 3'b000, 2'd0, 1'b0, 1'b0);

      // No preemption by a higher-priority requester.
      tick();
      expect_out("owner2", 3'b100, 2'd2, 1'b1, 1'b0);
      req = 3'b101; tick();
      expect_out("nopreempt_a", 3'b100, 2'd2, 1'b1, 1'b0);
      tick();
      expect_out("nopreempt_b", 3'b100, 2'd2, 1'b1, 1'b0);
      req = 3'b001; tick();
      expect_out("owner2_release", 3'b000, 2'd0, 1'b0, 1'b0);
      tick();
      expect_out("after_preempt", 3'b001, 2'd0, 1'b1, 1'b0);

      // Timeout: owner 0 keeps requesting. Its grant above was hold cycle 1 of 4.
      for (int i = 2; i <= 4; i++) begin
         tick();
         expect_out($sformatf("hold_%0d", i), 3'b001, 2'd0, 1'b1, 1'b0);
      end
      tick();
      expect_out("timeout_pulse", 3'b000, 2'd0, 1'b0, 1'b1);
      tick();
      expect_out("penalized_a", 3'b000, 2'd0, 1'b0, 1'b0);
      tick();
      expect_out("penalized_b", 3'b000, 2'd0, 1'b0, 1'b0);
      req = 3'b000; tick();
      expect_out("penalty_drop", 3'b000, 2'd0, 1'b0, 1'b0);
      req = 3'b001; tick();
      expect_out("regrant_0", 3'b001, 2'd0, 1'b1, 1'b0);

      // Reset while owner 1 holds the grant.
      req = 3'b000; tick();
      expect_out("pre_rst_release", 3'b000, 2'd0, 1'b0, 1'b0);
      req = 3'b010; tick();
      expect_out("pre_rst_grant1", 3'b010, 2'd1, 1'b1, 1'b0);
      rst = 1'b1; tick();
      expect_out("rst_midgrant", 3'b000, 2'd0, 1'b0, 1'b0);
      tick();
      expect_out("rst_held", 3'b000, 2'd0, 1'b0, 1'b0);
      rst = 1'b0;
      req = 3'b011; tick();
      expect_out("post_rst_fixed", 3'b001, 2'd0, 1'b1, 1'b0);

      // Fairness: all three request, each owner releases after 2 cycles and re-requests.
      rst = 1'b1; req = 3'b000; tick();
      rst = 1'b0; req = 3'b111;
      for (int k = 0; k < 4; k++) begin
         tick();
         expect_out($sformatf("fair_%0d_a", k), 3'b001 << rr_exp[k], rr_exp[k], 1'b1, 1'b0);
         tick();
         expect_out($sformatf("fair_%0d_b", k), 3'b001 << rr_exp[k], rr_exp[k], 1'b1, 1'b0);
         req = 3'b111 & ~(3'b001 << rr_exp[k]);
         tick();
         expect_out($sformatf("fair_%0d_gap", k), 3'b000, 2'd0, 1'b0, 1'b0);
         req = 3'b111;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
